// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver with a small receive FIFO and a servant-style Wishbone slave.
// DATA (adr 0) pops the FIFO head on read; STATUS (adr 1) reports FIFO state and W1C error flags.
//
// state | meaning
// IDLE  | waiting for rx_s low (start bit candidate)
// START | counting to mid start bit, rejecting glitches
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling stop bit, then push byte or flag framing error
module servant_uart_rx #(
  parameter int CLKS_PER_BIT = 278,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_irq
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic          rx_meta, rx_s;
  logic [1:0]    state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          overrun, frame_err;

  logic bit_tc, half_tc, stop_done;
  logic push_req, push, pop, empty, full;
  logic bus_req, ovr_set, ovr_clr, fe_set, fe_clr;
  logic [31:0] status, rd_data;
  logic unused;

  assign bit_tc    = (clk_cnt == BIT_TC);
  assign half_tc   = (clk_cnt == HALF_TC);
  assign stop_done = (state == STOP) && bit_tc;
  assign push_req  = stop_done && rx_s;
  assign fe_set    = stop_done && !rx_s;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign push    = push_req && !full;
  assign ovr_set = push_req && full;

  assign bus_req = i_wb_cyc && !o_wb_ack;
  assign pop     = bus_req && !i_wb_we && !i_wb_adr && !empty;
  assign ovr_clr = bus_req && i_wb_we && i_wb_adr && i_wb_dat[2];
  assign fe_clr  = bus_req && i_wb_we && i_wb_adr && i_wb_dat[3];

  assign status  = {23'b0, 5'(count), frame_err, overrun, full, !empty};
  assign rd_data = i_wb_adr ? status : (empty ? 32'h0 : {24'b0, mem[rptr]});
  assign unused  = ^{i_wb_dat[31:4], i_wb_dat[1:0]};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (half_tc) begin
            clk_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_tc) begin
            clk_cnt <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          // Return to IDLE on the sample cycle so a back-to-back start bit is not missed.
          if (bit_tc) begin
            clk_cnt <= '0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wptr] <= shreg;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      o_wb_ack  <= 1'b0;
      o_wb_rdt  <= '0;
      o_irq     <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Receiver set wins over a same-cycle firmware clear.
      overrun   <= ovr_set || (overrun && !ovr_clr);
      frame_err <= fe_set || (frame_err && !fe_clr);
      o_wb_ack  <= bus_req;
      if (bus_req) o_wb_rdt <= rd_data;
      o_irq     <= !empty;
    end
  end

endmodule

// File: doc/servant_uart_rx.md
Name: servant_uart_rx

Overview:
- UART receiver (8N1) with a small receive FIFO and a Wishbone slave register interface.
- Provides the serial input path for the servant SoC, complementing the existing GPIO-driven TX line.
- Firmware polls the status register or uses o_irq, then reads bytes from the data register.
- Sits beside the servant GPIO on the SoC Wishbone bus, clocked by the PLL-generated system clock.

Parameters:
- CLKS_PER_BIT, 278: system clocks per UART bit (32 MHz / 115200). Minimum 8.
- FIFO_DEPTH, 4: receive FIFO entries; power of 2, range 2..16.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous, active-low reset.
- i_rx  input  1  serial input, asynchronous to i_clk, idle high.
- i_wb_cyc  input  1  bus cycle request; servant style, no separate strobe.
- i_wb_we  input  1  write enable.
- i_wb_adr  input  1  register select (SoC address bit 2): 0 = DATA, 1 = STATUS.
- i_wb_dat  input  32  write data.
- o_wb_rdt  output  32  read data.
- o_wb_ack  output  1  single-cycle acknowledge.
- o_irq  output  1  high while the FIFO is non-empty.

Behaviour:
- Reset (async assert, sync release): synchronizer flops = 1, FSM = IDLE, counters = 0, FIFO empty, sticky flags = 0, o_wb_ack = 0, o_wb_rdt = 0, o_irq = 0.
- Input sync: i_rx passes through 2 flops; the FSM uses only the synchronized value rx_s.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_s == 0 -> START; bit counter cleared.
  - START: at count CLKS_PER_BIT/2 - 1 (integer division), sample rx_s. If 1, glitch -> IDLE with no flag. If 0 -> DATA with counter cleared.
  - DATA: every CLKS_PER_BIT clocks, sample rx_s into the shift register, LSB first. After the 8th bit -> STOP.
  - STOP: after CLKS_PER_BIT clocks, sample rx_s.
    - 1: push the byte, or, if the FIFO is full, drop it and set overrun.
    - 0: discard the byte and set frame_err.
    - In both cases -> IDLE in the same cycle, so a new start bit can be detected from the next clock.
- FIFO: circular buffer; count width log2(FIFO_DEPTH)+1.
  - A push and a pop in the same cycle both take effect and count is unchanged.
  - A push while full is dropped, even if a pop happens in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Wishbone timing: o_wb_ack <= i_wb_cyc & !o_wb_ack. The ack is high one cycle after cyc is asserted, stays high for exactly 1 cycle, and o_wb_rdt is valid in that cycle. Back-to-back cyc yields ack on alternate cycles.
- DATA read (adr = 0):
  - FIFO non-empty: rdt = {24'b0, head}; pop in the ack cycle.
  - FIFO empty: rdt = 0; no pop.
- DATA write: acked, ignored.
- STATUS read (adr = 1): rdt[0] = non-empty, [1] = full, [2] = overrun, [3] = frame_err, [8:4] = count (zero-extended), other bits = 0.
- STATUS write: W1C. i_wb_dat[2] clears overrun and i_wb_dat[3] clears frame_err, both in the ack cycle. If the same flag is set by the receiver in the same cycle, the set wins.
- o_rdt outside ack cycles: don't-care. The bench must check it only when ack = 1.
- o_irq: registered from the count and updated one cycle after a push or pop.
- Reset mid-frame: FSM aborts immediately to IDLE and the partial byte is lost. After release, the FSM does not resync until rx_s is seen low from IDLE; a low level at release is treated as a start bit.

Test Plan (CLKS_PER_BIT = 16, FIFO_DEPTH = 4):
- Single frame 0xA5, then DATA read -> irq rises about 10 bit-times plus 3 clocks after the start edge. Read returns 0x000000A5 with ack exactly one cycle after cyc. Next STATUS read returns 0x00000000.
- Four frames 0x01..0x04 sent, then a fifth frame 0x05 -> STATUS returns 0x00000047 (count 4, overrun, full, non-empty). The four DATA reads return 0x01..0x04, and a fifth read returns 0.
- Frame with stop bit = 0 -> no push; STATUS bit 3 = 1. Writing 0x8 to STATUS clears it to 0; writing 0x4 leaves frame_err set.
- Low glitch of 5 clocks on i_rx -> no push, no flags set, FSM back in IDLE; a following valid 0x3C frame is received correctly.
- Assert i_rst after the 4th data bit of a frame, hold 3 clocks, release with i_rx high -> all outputs zero. The next frame 0x7E is received correctly.
- Frame stop-bit sample coincides with a DATA read of a non-empty FIFO -> push and pop both occur; count unchanged and byte order preserved.
